// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and occupancy constants for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_e;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
  function automatic logic [1:0] occ_of(stage_state_e s);
    return s == ST_SKID ? OCC_TWO : s == ST_FULL ? OCC_ONE : OCC_EMPTY;
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready bus plus flush and occupancy of one stage
interface pipe_stage_reg_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  modport master (output flush, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, occupancy);
  modport slave  (input  flush, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: payload register with load enable and async reset to RESET_VAL
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional skid buffer and flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  stage_state_e     state_q, state_d;
  logic             ready_q, ready_d;
  logic             accept, emit, main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // ready_q mirrors state_d != ST_SKID so in_ready leaves a flop directly
  assign bus.in_ready  = SKID ? ready_q : (state_q == ST_EMPTY) | bus.out_ready;
  assign bus.out_valid = state_q != ST_EMPTY;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_of(state_q);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end

  always_comb begin
    accept  = bus.in_valid & bus.in_ready;
    emit    = bus.out_valid & bus.out_ready;
    state_d = bus.flush ? ST_EMPTY :
              state_q == ST_SKID ? (emit ? ST_FULL : ST_SKID) :
              accept ? ((state_q == ST_FULL && !emit && SKID) ? ST_SKID : ST_FULL) :
              emit ? ST_EMPTY : state_q;
    ready_d = state_d != ST_SKID;
    main_d  = state_q == ST_SKID ? skid_q : bus.in_data;
    main_en = !bus.flush && (state_q == ST_SKID ? emit : accept && (state_q == ST_EMPTY || emit));
    skid_en = !bus.flush && SKID && state_q == ST_FULL && accept && !emit;
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .reset(reset), .en(main_en), .d(main_d), .q(main_q)
  );

  if (SKID) begin : g_skid
    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk(clk), .reset(reset), .en(skid_en), .d(bus.in_data), .q(skid_q)
    );
  end else begin : g_noskid
    assign skid_q = RESET_VAL;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and scoreboarded checks of pipe_stage_reg for SKID=1 and SKID=0
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32)) if1 ();
  pipe_stage_reg_if #(.WIDTH(32)) if0 ();

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle(input bit drain);
    if1.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
    if1.in_data   = $urandom;
    if1.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    if0.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
    if0.in_data   = $urandom;
    if0.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    check("rnd1_occ", 32'(if1.occupancy), q1.size());
    check("rnd0_occ", 32'(if0.occupancy), q0.size());
    if (if1.out_valid && if1.out_ready) begin
      check("rnd1_nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) check("rnd1_data", if1.out_data, q1.pop_front());
    end
    if (if0.out_valid && if0.out_ready) begin
      check("rnd0_nonempty", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) check("rnd0_data", if0.out_data, q0.pop_front());
    end
    if (if1.in_valid && if1.in_ready) q1.push_back(if1.in_data);
    if (if0.in_valid && if0.in_ready) q0.push_back(if0.in_data);
    step();
  endtask

  initial begin
    reset = 1'b1;
    {if1.flush, if1.in_valid, if1.out_ready, if1.in_data} = '0;
    {if0.flush, if0.in_valid, if0.out_ready, if0.in_data} = '0;
    step();
    step();
    check("rst_valid", 32'(if1.out_valid), 32'd0);
    check("rst_occ", 32'(if1.occupancy), 32'd0);
    check("rst_data", if1.out_data, 32'd0);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(if1.in_ready), 32'd1);
    // streaming
    if1.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 32'(i);
      step();
      check("str_valid", 32'(if1.out_valid), 32'd1);
      check("str_data", if1.out_data, 32'(i));
    end
    if1.in_valid = 1'b0;
    step();
    check("str_idle", 32'(if1.out_valid), 32'd0);
    // stall into skid
    if1.out_ready = 1'b0;
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'hA;
    step();
    if1.in_data   = 32'hB;
    step();
    if1.in_valid  = 1'b0;
    #1;
    check("stall_occ", 32'(if1.occupancy), 32'd2);
    check("stall_ready", 32'(if1.in_ready), 32'd0);
    check("stall_data", if1.out_data, 32'hA);
    step();
    check("stall_hold_data", if1.out_data, 32'hA);
    check("stall_hold_valid", 32'(if1.out_valid), 32'd1);
    if1.out_ready = 1'b1;
    step();
    check("drain_b", if1.out_data, 32'hB);
    check("drain_b_occ", 32'(if1.occupancy), 32'd1);
    step();
    check("drain_idle", 32'(if1.out_valid), 32'd0);
    // flush from skid with in_valid
    if1.out_ready = 1'b0;
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'h1;
    step();
    if1.in_data   = 32'h2;
    step();
    if1.flush     = 1'b1;
    if1.in_data   = 32'hC;
    #1;
    check("fl_pre_occ", 32'(if1.occupancy), 32'd2);
    step();
    if1.flush     = 1'b0;
    if1.in_valid  = 1'b0;
    #1;
    check("fl_valid", 32'(if1.out_valid), 32'd0);
    check("fl_occ", 32'(if1.occupancy), 32'd0);
    check("fl_ready", 32'(if1.in_ready), 32'd1);
    if1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_quiet", 32'(if1.out_valid), 32'd0);
    end
    // flush from full while a beat is accepted
    if1.out_ready = 1'b0;
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'h3;
    step();
    if1.flush     = 1'b1;
    if1.in_data   = 32'hC;
    step();
    if1.flush     = 1'b0;
    if1.in_valid  = 1'b0;
    #1;
    check("fla_valid", 32'(if1.out_valid), 32'd0);
    check("fla_occ", 32'(if1.occupancy), 32'd0);
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'hD;
    if1.out_ready = 1'b1;
    step();
    if1.in_valid  = 1'b0;
    check("fla_next", if1.out_data, 32'hD);
    step();
    check("fla_idle", 32'(if1.out_valid), 32'd0);
    // reset mid-stream with two beats held
    if1.out_ready = 1'b0;
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'h11;
    step();
    if1.in_data   = 32'h22;
    step();
    if1.in_valid  = 1'b0;
    #1;
    check("mid_pre_occ", 32'(if1.occupancy), 32'd2);
    reset = 1'b1;
    #1;
    check("mid_valid", 32'(if1.out_valid), 32'd0);
    check("mid_occ", 32'(if1.occupancy), 32'd0);
    check("mid_data", if1.out_data, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("mid_ready", 32'(if1.in_ready), 32'd1);
    check("mid_idle", 32'(if1.out_valid), 32'd0);
    // SKID=0: combinational ready
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.in_data   = 32'h5;
    step();
    if0.in_valid  = 1'b0;
    #1;
    check("ns_valid", 32'(if0.out_valid), 32'd1);
    check("ns_ready_stall", 32'(if0.in_ready), 32'd0);
    if0.out_ready = 1'b1;
    #1;
    check("ns_ready_go", 32'(if0.in_ready), 32'd1);
    if0.in_valid  = 1'b1;
    if0.in_data   = 32'h6;
    step();
    if0.in_valid  = 1'b0;
    check("ns_repl_valid", 32'(if0.out_valid), 32'd1);
    check("ns_repl_data", if0.out_data, 32'h6);
    step();
    check("ns_idle", 32'(if0.out_valid), 32'd0);
    // random traffic against scoreboards
    if1.out_ready = 1'b0;
    if0.out_ready = 1'b0;
    for (int i = 0; i < 10000; i++) rnd_cycle(1'b0);
    for (int i = 0; i < 4; i++) rnd_cycle(1'b1);
    check("rnd1_left", q1.size(), 32'd0);
    check("rnd0_left", q0.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
